// File: rtl/pf_pkg.sv
// Shared widths, default queue depth and FSM encoding for the instruction prefetcher.
package pf_pkg;

    localparam int unsigned QDEPTH_DEF = 4;
    localparam int unsigned PC_W       = 5;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned ENTRY_W    = INSTR_W + PC_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } pf_state_t;

endpackage

// File: rtl/pf_fifo.sv
// Prefetch queue storage: power-of-two ring buffer with synchronous push, pop and clear.
// The head entry is read combinationally from the register array.
module pf_fifo
    import pf_pkg::*;
#(
    parameter int unsigned DEPTH = QDEPTH_DEF,
    parameter int unsigned W     = ENTRY_W
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and occupancy next-state; clear wins over any push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: streams sequential ROM reads into a small queue while
// the processor runs, with redirect (flush) support. One read may be in flight;
// its word lands in the queue one edge after issue.
module instr_prefetch
    import pf_pkg::*;
#(
    parameter int unsigned QDEPTH = QDEPTH_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               run,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_q,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_pc
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    pf_state_t         state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   infl_pc_q, infl_pc_d;
    logic              inflight_q, inflight_d;
    logic              kill_q, kill_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic [CW-1:0]     count;
    logic [CW-1:0]     occ;
    logic [ENTRY_W-1:0] head;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: follows run, but a flush edge holds the current state.
    always_comb begin
        state_d = state_q;
        if (!flush) begin
            state_d = run ? ST_STREAM : ST_IDLE;
        end
    end

    // FSM outputs: issue only with room for the queued plus in-flight words.
    always_comb begin
        occ   = count + CW'(inflight_q);
        issue = (state_q == ST_STREAM) && !flush && (occ < CW'(QDEPTH));
        push  = inflight_q && !kill_q && !flush;
        pop   = instr_valid && instr_ready && !flush;
    end

    // Fetch PC, in-flight tracking and kill next-state.
    always_comb begin
        pc_d       = pc_q;
        infl_pc_d  = infl_pc_q;
        inflight_d = issue;
        kill_d     = flush;
        if (flush) begin
            pc_d = flush_pc;
        end else if (issue) begin
            pc_d      = pc_q + PC_W'(1);
            infl_pc_d = pc_q;
        end
    end

    // Fetch PC, in-flight and kill registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pc_q       <= '0;
            infl_pc_q  <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            infl_pc_q  <= infl_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    pf_fifo #(
        .DEPTH (QDEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (flush),
        .push      (push),
        .push_data ({rom_q, infl_pc_q}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign rom_addr    = pc_q;
    assign instr_valid = (count != '0);
    // Head fields are masked when empty so reset/flush present zeros.
    assign instr       = instr_valid ? head[ENTRY_W-1:PC_W] : '0;
    assign instr_pc    = instr_valid ? head[PC_W-1:0]       : '0;

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_instr_prefetch;

    localparam int QD = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic        instr_ready = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  flush_pc = '0;
    logic [4:0]  rom_addr;
    logic [4:0]  instr_pc;
    logic [15:0] rom_q = '0;
    logic [15:0] instr;
    logic        instr_valid;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [15:0] d;
        logic [4:0]  pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_stream = 1'b0;
    bit          m_infl = 1'b0;
    bit          m_iss;
    logic [4:0]  m_pc = '0;
    logic [4:0]  m_ipc = '0;

    logic [4:0]  got_pc[$];
    logic [15:0] got_d[$];

    instr_prefetch #(.QDEPTH(QD)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .run         (run),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .flush_pc    (flush_pc)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: word at address a is 16'h1000 + a.
    always @(posedge clock) rom_q <= 16'h1000 + 16'(rom_addr);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Reference model: queue of {word, pc}, fetch pointer and one in-flight slot.
    always @(posedge clock) begin
        if (!resetn) begin
            m_stream = 1'b0;
            m_pc     = '0;
            m_infl   = 1'b0;
            mq.delete();
        end else begin
            m_iss = m_stream && !flush && ((mq.size() + int'(m_infl)) < QD);
            if (flush) begin
                mq.delete();
                m_pc = flush_pc;
            end else begin
                if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
                if (m_infl) mq.push_back(ent_t'{d: 16'h1000 + 16'(m_ipc), pc: m_ipc});
                if (m_iss) begin
                    m_ipc = m_pc;
                    m_pc  = m_pc + 5'd1;
                end
            end
            m_infl = m_iss;
            if (!flush) m_stream = run;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_valid", 32'(instr_valid), 32'(mq.size() != 0));
            check("cyc_rom_addr", 32'(rom_addr), 32'(m_pc));
            if (mq.size() != 0) begin
                check("cyc_instr", 32'(instr), 32'(mq[0].d));
                check("cyc_instr_pc", 32'(instr_pc), 32'(mq[0].pc));
            end
        end
    end

    // Record every word actually consumed by the processor.
    always @(negedge clock) begin
        if (resetn && instr_valid && instr_ready && !flush) begin
            got_pc.push_back(instr_pc);
            got_d.push_back(instr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset and start-up latency, then fill to depth.
        step(2);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk_en = 1'b1;
        resetn = 1'b1;
        step(1);
        run = 1'b1;
        step(1);
        check("start_valid_e0", 32'(instr_valid), 32'd0);
        step(1);
        check("start_valid_e1", 32'(instr_valid), 32'd0);
        step(1);
        check("start_valid_e2", 32'(instr_valid), 32'd1);
        check("start_instr", 32'(instr), 32'h1000);
        check("start_instr_pc", 32'(instr_pc), 32'd0);
        step(4);
        check("fill_stop_addr", 32'(rom_addr), 32'd4);
        check("fill_head_pc", 32'(instr_pc), 32'd0);

        // Continuous consumption with PC wrap.
        got_pc.delete(); got_d.delete();
        instr_ready = 1'b1;
        step(36);
        check("stream_count", 32'(got_pc.size()), 32'd36);
        for (int i = 0; i < 36; i++) begin
            check("stream_pc", 32'(got_pc[i]), 32'(i % 32));
            check("stream_data", 32'(got_d[i]), 32'(16'h1000 + 16'(i % 32)));
        end

        // Flush with 3 queued words and one read in flight.
        instr_ready = 1'b0;
        for (int k = 0; k < 10 && !(mq.size() == 3 && m_infl); k++) step(1);
        check("flush_setup", 32'(mq.size() == 3 && m_infl), 32'd1);
        flush = 1'b1; flush_pc = 5'd20;
        step(1);
        flush = 1'b0;
        check("flush_valid_f0", 32'(instr_valid), 32'd0);
        check("flush_rom_addr", 32'(rom_addr), 32'd20);
        step(1);
        check("flush_valid_f1", 32'(instr_valid), 32'd0);
        step(1);
        check("flush_valid_f2", 32'(instr_valid), 32'd1);
        check("flush_instr", 32'(instr), 32'h1014);
        check("flush_instr_pc", 32'(instr_pc), 32'd20);
        got_pc.delete(); got_d.delete();
        instr_ready = 1'b1;
        step(3);
        for (int i = 0; i < 3; i++) check("flush_seq_pc", 32'(got_pc[i]), 32'(20 + i));

        // Flush coinciding with instr_ready.
        instr_ready = 1'b0;
        step(3);
        instr_ready = 1'b1; flush = 1'b1; flush_pc = 5'd20;
        step(1);
        flush = 1'b0;
        check("flushrdy_valid", 32'(instr_valid), 32'd0);
        got_pc.delete(); got_d.delete();
        step(2);
        check("flushrdy_instr", 32'(instr), 32'h1014);
        check("flushrdy_instr_pc", 32'(instr_pc), 32'd20);
        step(6);
        check("flushrdy_count", 32'(got_pc.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("flushrdy_pc", 32'(got_pc[i]), 32'(20 + i));

        // Run drop with 2 queued + 1 in flight.
        instr_ready = 1'b0; run = 1'b0; resetn = 1'b0;
        step(1);
        resetn = 1'b1; run = 1'b1;
        step(3);
        run = 1'b0;
        step(1);
        check("rundrop_model_q", 32'(mq.size()), 32'd2);
        check("rundrop_model_infl", 32'(m_infl), 32'd1);
        got_pc.delete(); got_d.delete();
        instr_ready = 1'b1;
        step(8);
        check("rundrop_count", 32'(got_pc.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("rundrop_pc", 32'(got_pc[i]), 32'(i));
        check("rundrop_valid", 32'(instr_valid), 32'd0);
        check("rundrop_rom_addr", 32'(rom_addr), 32'd3);

        // Flush while idle loads the PC but does not start fetching.
        flush = 1'b1; flush_pc = 5'd7;
        step(1);
        flush = 1'b0;
        check("idleflush_addr", 32'(rom_addr), 32'd7);
        step(3);
        check("idleflush_hold", 32'(rom_addr), 32'd7);
        check("idleflush_valid", 32'(instr_valid), 32'd0);

        // Mid-stream reset for one edge, then restart from address 0.
        run = 1'b1;
        step(12);
        resetn = 1'b0;
        step(1);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_rom_addr", 32'(rom_addr), 32'd0);
        check("midrst_instr", 32'(instr), 32'd0);
        check("midrst_instr_pc", 32'(instr_pc), 32'd0);
        resetn = 1'b1;
        got_pc.delete(); got_d.delete();
        step(10);
        check("midrst_count", 32'(got_pc.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("midrst_pc", 32'(got_pc[i]), 32'(i));
            check("midrst_data", 32'(got_d[i]), 32'(16'h1000 + 16'(i)));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
